branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Successor to the combinational jump resolver: resolves JZ/JN/JC/JMP in EX, predicts branches at fetch, and generates registered flush/redirect on mispredict.
- Prediction uses a direct-mapped table per entry: 2-bit saturating counter, valid bit, tag and target (a branch target buffer, BTB).
- Sits between fetch (PC select) and the EX-stage flag/branch logic.

Parameters:
- PC_W, 32, PC width.
- TGT_W, 16, stored target width; zero-extended to PC_W.
- DEPTH, 16, table entries; power of 2; IDX_W = log2(DEPTH).
- PC_STEP, 1, fall-through increment.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- f_valid  in  1  fetch lookup request.
- f_pc  in  PC_W  fetch PC.
- f_pred_taken  out  1  combinational prediction.
- f_pred_target  out  PC_W  predicted target; 0 when f_pred_taken=0.
- r_valid  in  1  EX holds a branch instruction.
- r_pc  in  PC_W  PC of the resolving branch.
- r_jtype  in  2  0=JZ, 1=JN, 2=JC, 3=JMP.
- r_ccr  in  3  flags: [0]=Z, [1]=N, [2]=C.
- r_rdst  in  TGT_W  actual target.
- r_pred_taken  in  1  prediction carried down the pipe.
- r_pred_target  in  PC_W  target prediction carried down the pipe.
- taken  out  1  combinational actual outcome.
- flush  out  1  registered mispredict pulse.
- redirect_pc  out  PC_W  registered corrected PC; valid while flush=1.

Behaviour:
- Reset (rst=0, async):
  - flush=0, redirect_pc=0.
  - All counters set to 01 (weak not-taken); all valid bits cleared.
  - Reset mid-operation aborts any pending flush.
- Index and tag: index = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W].
- Lookup (combinational):
  - hit = valid & tag match.
  - f_pred_taken = f_valid & hit & ctr[1].
  - f_pred_target = zero-extended stored target when f_pred_taken=1, else 0.
- Resolve (combinational):
  - taken = r_valid & (JMP | (JZ & Z) | (JN & N) | (JC & C)).
  - r_valid=0 forces taken=0.
- Mispredict:
  - mis = r_valid & (taken != r_pred_taken | (taken & r_pred_target != {0, r_rdst})).
  - A resolve in a cycle where flush=1 is wrong-path: it is ignored (no update, no flush).
- Flush timing (registered):
  - Next edge after a mispredict: flush=1 for exactly one cycle.
  - redirect_pc = {0, r_rdst} if taken, else r_pc + PC_STEP.
  - redirect_pc wraps modulo 2^PC_W.
- Table update, on an accepted resolve at the clock edge:
  - Counter saturates: increments toward 11 on taken, decrements toward 00 on not-taken; no wrap at 00 or 11.
  - On taken: set valid, write tag and r_rdst.
  - On not-taken with a tag mismatch: counter at that index unchanged, entry not allocated.
  - On a tag mismatch with taken: replace the entry and set the counter to 10.
- Simultaneous lookup and update of the same index: lookup returns the old (pre-edge) contents; no bypass.
- Latency: prediction 0 cycles; flush 1 cycle after resolve; table update visible on the cycle after the edge.

Optional Feature:
- Macro: BPU_PERF_EN.
- With the macro defined:
  - Extra outputs branch_cnt[31:0] and mispred_cnt[31:0].
  - branch_cnt increments on each accepted resolve; mispred_cnt increments on each accepted mispredict.
  - Both counters wrap at 2^32 and reset to 0.
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package bpu_pkg:
  - jtype localparams JZ/JN/JC/JMP.
  - CCR bit indices Z_BIT=0, N_BIT=1, C_BIT=2.
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - Saturating-update function.
- One sub-module: bpu_table, holding storage, async clear, one combinational read port and one synchronous write port.
- Resolve/flush logic stays in the top level.

Test Plan:
- Reset, then f_pc=0x0005 -> f_pred_taken=0, f_pred_target=0; flush=0.
- JMP at r_pc=0x0005, r_rdst=0x0040, r_pred_taken=0 -> taken=1; next cycle flush=1, redirect_pc=0x00000040; next f_pc=0x0005 -> f_pred_taken=1, f_pred_target=0x40.
- JZ at 0x0010 with Z=0, predicted not-taken -> taken=0, no flush; repeat with Z=1, predicted 0 -> flush, redirect_pc=0x{0, rdst}.
- Four taken JN resolves at one PC, then three not-taken -> counter path 10→11→11→11→10→01→00; no saturation wrap; prediction drops after the second not-taken.
- Mispredict followed by r_valid=1 in the flush cycle -> second resolve ignored; table unchanged; flush stays a single-cycle pulse.
- Fall-through mispredict at r_pc=0xFFFFFFFF, predicted taken, Z=0 -> redirect_pc=0x00000000 (wrap); rst asserted mid-flush-cycle -> flush=0 immediately, all entries invalid.

Source files
------------

// File: rtl/bpu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bpu_pkg
// Description : Shared jump-type codes, flag bit positions, counter encodings
//               and the saturating counter update used by the predictor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package bpu_pkg;

    localparam logic [1:0] JZ  = 2'd0;
    localparam logic [1:0] JN  = 2'd1;
    localparam logic [1:0] JC  = 2'd2;
    localparam logic [1:0] JMP = 2'd3;

    localparam int Z_BIT = 0;
    localparam int N_BIT = 1;
    localparam int C_BIT = 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Move one step toward ST (up=1) or SNT (up=0), holding at either end.
    function automatic ctr_t sat_update(input ctr_t c, input logic up);
        ctr_t n;
        n = c;
        unique case (c)
            SNT: n = up ? WNT : SNT;
            WNT: n = up ? WT  : SNT;
            WT:  n = up ? ST  : WNT;
            ST:  n = up ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_table.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bpu_table
// Description : Direct-mapped branch target buffer: counter/valid/tag/target per
//               entry, one combinational lookup port, one update port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module bpu_table
    import bpu_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int TGT_W = 16,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int TAG_W = PC_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output ctr_t             rd_ctr,
    output logic [TGT_W-1:0] rd_tgt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [TGT_W-1:0] wr_tgt
);

    ctr_t             r_ctr [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [TGT_W-1:0] r_tgt [DEPTH];

    logic             w_wr_hit;

    assign rd_hit   = r_vld[rd_idx] && (r_tag[rd_idx] == rd_tag);
    assign rd_ctr   = r_ctr[rd_idx];
    assign rd_tgt   = r_tgt[rd_idx];

    assign w_wr_hit = r_vld[wr_idx] && (r_tag[wr_idx] == wr_tag);

    // A not-taken branch that misses leaves the entry alone; a taken miss evicts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= WNT;
            end
            r_vld <= '0;
        end else if (wr_en) begin
            if (wr_taken) begin
                r_vld[wr_idx] <= 1'b1;
                r_ctr[wr_idx] <= w_wr_hit ? sat_update(r_ctr[wr_idx], 1'b1) : WT;
            end else if (w_wr_hit) begin
                r_ctr[wr_idx] <= sat_update(r_ctr[wr_idx], 1'b0);
            end
        end
    end

    // Tag and target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_taken) begin
            r_tag[wr_idx] <= wr_tag;
            r_tgt[wr_idx] <= wr_tgt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : branch_predict_unit
// Description : Fetch-time BTB prediction, EX-stage JZ/JN/JC/JMP resolution and
//               registered flush/redirect on mispredict. Define BPU_PERF_EN to
//               add branch/mispredict event counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int TGT_W   = 16,
    parameter int DEPTH   = 16,
    parameter int PC_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic [PC_W-1:0]  f_pc,
    output logic             f_pred_taken,
    output logic [PC_W-1:0]  f_pred_target,
    input  logic             r_valid,
    input  logic [PC_W-1:0]  r_pc,
    input  logic [1:0]       r_jtype,
    input  logic [2:0]       r_ccr,
    input  logic [TGT_W-1:0] r_rdst,
    input  logic             r_pred_taken,
    input  logic [PC_W-1:0]  r_pred_target,
    output logic             taken,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc
`ifdef BPU_PERF_EN
    ,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = PC_W - IDX_W;

    logic             w_rd_hit;
    ctr_t             w_rd_ctr;
    logic [TGT_W-1:0] w_rd_tgt;
    logic             w_cond;
    logic             w_mis;
    logic             w_accept;
    logic             w_flush_nxt;
    logic [PC_W-1:0]  w_rdst_ext;

    logic             r_flush;
    logic [PC_W-1:0]  r_redirect;

    bpu_table #(
        .PC_W  (PC_W),
        .TGT_W (TGT_W),
        .DEPTH (DEPTH)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (f_pc[IDX_W-1:0]),
        .rd_tag   (f_pc[PC_W-1:IDX_W]),
        .rd_hit   (w_rd_hit),
        .rd_ctr   (w_rd_ctr),
        .rd_tgt   (w_rd_tgt),
        .wr_en    (w_accept),
        .wr_idx   (r_pc[IDX_W-1:0]),
        .wr_tag   (r_pc[PC_W-1:IDX_W]),
        .wr_taken (taken),
        .wr_tgt   (r_rdst)
    );

    assign f_pred_taken  = f_valid && w_rd_hit && (w_rd_ctr inside {WT, ST});
    assign f_pred_target = f_pred_taken ? PC_W'(w_rd_tgt) : '0;

    always_comb begin
        w_cond = 1'b0;
        unique case (r_jtype)
            JZ:      w_cond = r_ccr[Z_BIT];
            JN:      w_cond = r_ccr[N_BIT];
            JC:      w_cond = r_ccr[C_BIT];
            JMP:     w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign taken       = r_valid && w_cond;
    assign w_rdst_ext  = PC_W'(r_rdst);
    assign w_mis       = r_valid && ((taken != r_pred_taken) ||
                                     (taken && (r_pred_target != w_rdst_ext)));
    // Anything resolving while flush is high is on the squashed path.
    assign w_accept    = r_valid && !r_flush;
    assign w_flush_nxt = w_accept && w_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush    <= 1'b0;
            r_redirect <= '0;
        end else begin
            r_flush <= w_flush_nxt;
            if (w_flush_nxt) begin
                r_redirect <= taken ? w_rdst_ext : (r_pc + PC_W'(PC_STEP));
            end
        end
    end

    assign flush       = r_flush;
    assign redirect_pc = r_redirect;

`ifdef BPU_PERF_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_flush_nxt) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
`endif

endmodule
`default_nettype wire
